key_onehot_latch: RTL and testbench

KEY_ONEHOT_LATCH -- requirements
Module: key_onehot_latch

---
 rtl/key_onehot_latch.sv | 128 ++++++++++++
 tb/tb_key_onehot_latch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_onehot_latch.sv
// key_onehot_latch: eight push-buttons, each debounced and edge-detected;
// the first press (or set of simultaneous presses) is latched on dat_out
// until clr releases it. multi flags a capture with more than one key set.
// Build option: define KEY_SYNC_EN to add a two-flop synchronizer per key
// bit ahead of the debouncer (adds two cycles of press latency).
module key_onehot_latch #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       clr,
    output logic [7:0] dat_out,
    output logic       valid,
    output logic       multi
);

    // Counter holds 0..DEB_CYCLES-1; sized to hold DEB_CYCLES itself.
    localparam int unsigned   CW     = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t        state;
    logic [7:0]    samp;       // per-bit sample fed to the debouncer
    logic [7:0]    lvl;        // debounced level per key
    logic [7:0]    lvl_d;      // previous debounced level, for edge detection
    logic [7:0]    press;      // keys whose debounced level just rose
    logic          multi_nxt;  // more than one bit set in press
    logic [CW-1:0] cnt [8];    // consecutive differing-sample count per key

`ifdef KEY_SYNC_EN
    logic [7:0] sync1;
    logic [7:0] sync2;

    // Two-flop synchronizer bringing the raw button levels into clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = key_in;
`endif

    // Debouncer: level flips only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (samp[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == C_LAST) begin
                    lvl[i] <= ~lvl[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + C_ONE;
                end
            end
        end
    end

    // Delayed copy of the debounced level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d <= '0;
        end else begin
            lvl_d <= lvl;
        end
    end

    // Press events: 0->1 transitions of the debounced level only
    always_comb begin
        press     = lvl & ~lvl_d;
        multi_nxt = |(press & (press - 8'd1));
    end

    // Capture FSM: latch the first press vector, hold until clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dat_out <= '0;
            valid   <= 1'b0;
            multi   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|press) begin
                        state   <= HELD;
                        dat_out <= press;
                        valid   <= 1'b1;
                        multi   <= multi_nxt;
                    end
                end
                HELD: begin
                    // A press arriving together with clr is dropped, not queued.
                    if (clr) begin
                        state   <= IDLE;
                        dat_out <= '0;
                        valid   <= 1'b0;
                        multi   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dat_out <= '0;
                    valid   <= 1'b0;
                    multi   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_onehot_latch.sv
// Testbench for key_onehot_latch: directed scenarios plus randomized key
// activity; a reference model pushes expected capture/release events into
// a queue that a monitor drains whenever valid changes.
module tb_key_onehot_latch;

    localparam int unsigned DEB = 4;
`ifdef KEY_SYNC_EN
    localparam int unsigned LAT = DEB + 2;
`else
    localparam int unsigned LAT = DEB;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic [7:0] dat_out;
    logic       valid;
    logic       multi;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          is_cap;
        logic [7:0]  vec;
        bit          mul;
        int unsigned cyc;
    } ev_t;

    ev_t expq[$];

    // reference model state
    int unsigned cyc = 0;
    bit          m_held = 1'b0;
    logic [7:0]  m_lvl = 8'h00;
    logic [7:0]  m_press = 8'h00;
    logic [7:0]  m_hist[$];
    logic [7:0]  m_dl[$];

    key_onehot_latch #(.DEB_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .clr    (clr),
        .dat_out(dat_out),
        .valid  (valid),
        .multi  (multi)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        if (m_held) begin
            // a capture made this very cycle was never visible; drop it
            if (expq.size() > 0 && expq[$].is_cap && expq[$].cyc == cyc)
                void'(expq.pop_back());
            else
                expq.push_back('{is_cap: 1'b0, vec: 8'h00, mul: 1'b0, cyc: cyc});
        end
        m_held  = 1'b0;
        m_lvl   = 8'h00;
        m_press = 8'h00;
        m_hist.delete();
        m_dl.delete();
`ifdef KEY_SYNC_EN
        repeat (2) m_dl.push_back(8'h00);
`endif
    endtask

    task automatic m_step();
        logic [7:0] s;
        logic [7:0] ev;
        logic [7:0] newp;
        bit         all_diff;
        cyc++;
        ev = m_press;
        if (m_held) begin
            if (clr) begin
                m_held = 1'b0;
                expq.push_back('{is_cap: 1'b0, vec: 8'h00, mul: 1'b0, cyc: cyc});
            end
        end else if (ev != 8'h00) begin
            m_held = 1'b1;
            expq.push_back('{is_cap: 1'b1, vec: ev, mul: ($countones(ev) > 1), cyc: cyc});
        end
`ifdef KEY_SYNC_EN
        s = m_dl.pop_front();
        m_dl.push_back(key_in);
`else
        s = key_in;
`endif
        m_hist.push_back(s);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        newp = 8'h00;
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                foreach (m_hist[j]) if (m_hist[j][i] == m_lvl[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[i] = ~m_lvl[i];
                    if (m_lvl[i]) newp[i] = 1'b1;
                end
            end
        end
        m_press = newp;
    endtask

    // reference model process
    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // monitor: pops an expected event whenever valid changes
    initial begin
        logic       pv;
        logic [7:0] pd;
        logic       pm;
        ev_t        e;
        pv = 1'b0;
        pd = 8'h00;
        pm = 1'b0;
        forever begin
            @(negedge clk);
            tests++;
            if (valid !== pv) begin
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: valid=%b dat_out=%h multi=%b at cycle %0d, no event expected",
                             valid, dat_out, multi, cyc);
                end else begin
                    e = expq.pop_front();
                    if (valid !== logic'(e.is_cap) || e.cyc != cyc ||
                        dat_out !== e.vec || multi !== logic'(e.mul)) begin
                        fails++;
                        $display("FAIL sb_event: got valid=%b dat_out=%h multi=%b cycle %0d, want valid=%b dat_out=%h multi=%b cycle %0d",
                                 valid, dat_out, multi, cyc, e.is_cap, e.vec, e.mul, e.cyc);
                    end
                end
            end else if (dat_out !== pd || multi !== pm) begin
                fails++;
                $display("FAIL sb_stable: dat_out=%h multi=%b changed without valid edge, was dat_out=%h multi=%b",
                         dat_out, multi, pd, pm);
            end
            pv = valid;
            pd = dat_out;
            pm = multi;
        end
    end

    task automatic check_out(input string name, input logic [7:0] ed, input logic ev, input logic em);
        tests++;
        if (dat_out !== ed || valid !== ev || multi !== em) begin
            fails++;
            $display("FAIL %s: got dat_out=%h valid=%b multi=%b, want dat_out=%h valid=%b multi=%b",
                     name, dat_out, valid, multi, ed, ev, em);
        end
    endtask

    task automatic pulse_reset_midcycle(input string name);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_out(name, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // stimulus
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_out("reset_state", 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        key_in = 8'h04;
        repeat (LAT) @(negedge clk);
        check_out("before_latency", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_out("single_press", 8'h04, 1'b1, 1'b0);
        repeat (14) @(negedge clk);
        check_out("hold_stable", 8'h04, 1'b1, 1'b0);

        key_in = 8'h14;
        repeat (LAT + 4) @(negedge clk);
        check_out("held_ignores_press", 8'h04, 1'b1, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_out("clr_release", 8'h00, 1'b0, 1'b0);
        repeat (LAT + 4) @(negedge clk);
        check_out("no_recapture_held_key", 8'h00, 1'b0, 1'b0);
        key_in = 8'h00;
        repeat (LAT + 4) @(negedge clk);
        key_in = 8'h10;
        repeat (LAT + 1) @(negedge clk);
        check_out("repress_captured", 8'h10, 1'b1, 1'b0);

        key_in = 8'h00;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        key_in = 8'h02;
        repeat (DEB - 1) @(negedge clk);
        key_in = 8'h00;
        repeat (LAT + 4) @(negedge clk);
        check_out("glitch_rejected", 8'h00, 1'b0, 1'b0);

        key_in = 8'h81;
        repeat (LAT) @(negedge clk);
        @(negedge clk);
        check_out("multi_press", 8'h81, 1'b1, 1'b1);

        key_in = 8'h02;
        repeat (LAT + 4) @(negedge clk);
        check_out("held_keeps_multi", 8'h81, 1'b1, 1'b1);
        pulse_reset_midcycle("async_reset_held");
        @(negedge clk);
        repeat (LAT) @(negedge clk);
        check_out("reset_before_latency", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_out("reset_recapture", 8'h02, 1'b1, 1'b0);

        key_in = 8'h0A;
        repeat (LAT) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_out("clr_beats_press", 8'h00, 1'b0, 1'b0);
        repeat (LAT + 4) @(negedge clk);
        check_out("event_discarded", 8'h00, 1'b0, 1'b0);

        key_in = 8'h00;
        repeat (LAT + 4) @(negedge clk);
        key_in = 8'h20;
        repeat (LAT) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_out("clr_idle_no_effect", 8'h20, 1'b1, 1'b0);

        key_in = 8'h00;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 15) == 0) key_in[i] = ~key_in[i];
            end
            clr = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset_midcycle("rand_async_reset");
        end

        clr = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL queue_drained: %0d expected events never seen, want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
